// File: rtl/reflet_periph_arbiter.sv
// Two-master (CPU = m0, DMA = m1) round-robin arbiter for a shared peripheral bus.
// Each access runs IDLE -> ACCESS -> DONE. Optional bus lock: define REFLET_ARB_LOCK_EN.
module reflet_periph_arbiter #(
   parameter int base_addr_size = 16,
   parameter int word_size      = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      m0_req,
   input  logic [base_addr_size-1:0] m0_addr,
   input  logic [word_size-1:0]      m0_wdata,
   input  logic                      m0_we,
   output logic                      m0_ack,
   input  logic                      m1_req,
   input  logic [base_addr_size-1:0] m1_addr,
   input  logic [word_size-1:0]      m1_wdata,
   input  logic                      m1_we,
   output logic                      m1_ack,
`ifdef REFLET_ARB_LOCK_EN
   input  logic                      m0_lock,
   input  logic                      m1_lock,
`endif
   output logic [word_size-1:0]      rdata,
   output logic                      p_enable,
   output logic [base_addr_size-1:0] p_addr,
   output logic [word_size-1:0]      p_wdata,
   output logic                      p_we,
   input  logic [word_size-1:0]      p_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t state, next_state;
   logic   owner;       // 0 = m0, 1 = m1
   logic   last_owner;
   logic   winner;
   logic   any_req;

   assign any_req = m0_req | m1_req;

`ifdef REFLET_ARB_LOCK_EN
   logic locked;
   logic owner_lock;
   logic owner_req;

   assign owner_lock = owner ? m1_lock : m0_lock;
   assign owner_req  = owner ? m1_req  : m0_req;
`endif

   always_comb begin
      winner = 1'b0;
      if (m0_req && m1_req)
         winner = ~last_owner;
      else if (m1_req)
         winner = 1'b1;
`ifdef REFLET_ARB_LOCK_EN
      // A locked owner keeps the bus as long as it keeps asking for it.
      if (locked && owner_req)
         winner = owner;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         rdata      <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && any_req)
            owner <= winner;
         if (state == ACCESS)
            rdata <= p_rdata;
         if (state == DONE)
            last_owner <= owner;
      end
   end

`ifdef REFLET_ARB_LOCK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         locked <= 1'b0;
      else if (state == DONE)
         locked <= owner_lock;
      else if (state == IDLE && (!owner_lock || !owner_req))
         locked <= 1'b0;
   end
`endif

   always_comb begin
      next_state = state;
      p_enable   = 1'b0;
      p_we       = 1'b0;
      p_addr     = '0;
      p_wdata    = '0;
      m0_ack     = 1'b0;
      m1_ack     = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_req)
               next_state = ACCESS;
         end
         ACCESS: begin
            p_enable   = 1'b1;
            p_we       = owner ? m1_we    : m0_we;
            p_addr     = owner ? m1_addr  : m0_addr;
            p_wdata    = owner ? m1_wdata : m0_wdata;
            next_state = DONE;
         end
         DONE: begin
            m0_ack     = ~owner;
            m1_ack     = owner;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule
